wb_burst_master: RTL and testbench
==================================

Name: wb_burst_master

Overview:
Synthesizable Wishbone B3 initiator. It takes transfer commands (address, beat count, direction, burst type) on a valid/ready port. It issues classic or incrementing/wrapping burst cycles toward a Wishbone slave such as the memory model, sources write beats from a stream input and returns read beats on a stream output. It is used as the traffic engine in SoC benches and as the DMA front-end of bus bridges.

Parameters:
- aw, 32: address width.
- dw, 32: data width; byte lanes = dw/8, must be 32 (sel is 4 bits).
- MAX_RETRIES, 4: rty responses tolerated per beat before the transfer is failed.
- TIMEOUT_CYCLES, 256: watchdog limit; used only with the optional feature.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_adr_i  in  aw  start byte address (word aligned).
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_len_i  in  8  beats minus 1 (0 = single beat).
- cmd_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- cmd_sel_i  in  4  byte select for all beats.
- wdat_i  in  dw  write beat data.
- wdat_valid_i  in  1  write beat valid.
- wdat_ready_o  out  1  write beat taken when valid&ready.
- rdat_o  out  dw  read beat data.
- rdat_valid_o  out  1  read beat strobe; no backpressure.
- done_o  out  1  one-cycle pulse at transfer end.
- err_o  out  1  status, valid with done_o: 1 = aborted.
- wb_adr_o  out  aw  Wishbone address.
- wb_dat_o  out  dw  Wishbone write data.
- wb_sel_o  out  4  Wishbone byte select.
- wb_we_o  out  1  Wishbone write enable.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cti_o  out  3  Wishbone cycle type identifier.
- wb_bte_o  out  2  Wishbone burst type extension.
- wb_dat_i  in  dw  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- wb_rty_i  in  1  Wishbone retry.

Behaviour:
- Reset: the one clock is wb_clk_i; reset is asynchronous, active-high on wb_rst_i. All outputs are registered and clear to 0 asynchronously. FSM goes to IDLE; the write buffer and counters clear.
- IDLE: cmd_ready_o=1. On handshake, latch adr/len/we/bte/sel; beat counter = len. Go to FILL (write) or BUS (read).
- FILL: cyc=1, stb=0, wdat_ready_o=1. On a wdat handshake, load the write buffer and go to BUS the next cycle.
- BUS: cyc=1, stb=1. Outputs per beat:
  - wb_cti_o = 000 when len=0; 010 on non-final burst beats; 111 on the final beat.
  - wb_bte_o = latched bte.
- On ack:
  - Read: rdat_o/rdat_valid_o are registered and appear 1 cycle after the ack edge.
  - Write: the buffer empties. wdat_ready_o is combinationally high in the ack cycle, so a same-cycle refill keeps stb high (zero-wait burst). Without a refill, go to FILL.
  - Counter==0: drop cyc/stb next cycle, pulse done_o with err_o=0, return to IDLE.
  - Otherwise decrement the counter and advance the address.
- Address advance is +4 bytes. Wrap modes keep adr[aw-1:2+N] fixed and wrap the low N word bits, N = 2/3/4 for wrap4/8/16. Linear mode wraps at 2^aw.
- err: drop cyc/stb next cycle, pulse done_o with err_o=1, return to IDLE. Remaining write beats are not consumed.
- rty: deassert stb for exactly 1 cycle, keeping cyc and the current beat address/data, then reissue. More than MAX_RETRIES on one beat is treated as err. The retry count resets on each ack.
- Simultaneous ack/err/rty: priority err > rty > ack.
- cmd_ready_o is 0 outside IDLE. A new command is accepted no earlier than the cycle after done_o.
- Reset mid-transfer: cyc/stb drop immediately. No done_o pulse.

Optional Feature:
- WB_BURST_MASTER_TIMEOUT_EN defined: a watchdog counts cycles in BUS without ack/err/rty. When it reaches TIMEOUT_CYCLES, the transfer ends exactly as on err. The counter clears on any response or on leaving BUS.
- Undefined: no watchdog logic; the master waits indefinitely.

Decomposition:
- Package wb_common_pkg holds:
  - CTI constants CLASSIC=000, CONST_BURST=001, INC_BURST=010, END_BURST=111.
  - BTE constants LINEAR/WRAP4/WRAP8/WRAP16.
  - FSM state enum IDLE/FILL/BUS.
- One sub-module, wb_next_adr: combinational next address from adr and bte. It is shared with future slaves.

Test Plan:
- Single read, adr 0x100, len 0, ack after 2 waits: cti=000, one rdat_valid_o with the slave word, done_o with err_o=0, cyc low after ack.
- Write burst, adr 0x0, len 3, linear, wdat always valid, zero-wait slave: stb high 4 consecutive cycles, adr 0x0/4/8/C, cti 010,010,010,111, 4 wdat handshakes.
- Read wrap4 from 0x38, len 3: adr sequence 0x38,0x3C,0x30,0x34; bte=01.
- Write len 1 with wdat_valid low 5 cycles between beats: cyc held, stb low during the gap, second beat correct.
- rty on beat 0 twice, then ack: stb low 1 cycle after each rty, same adr reissued, done_o with err_o=0. With 5 rtys: done_o with err_o=1.
- err on beat 2 of len-7 read: 2 rdat beats, done_o with err_o=1, cyc low next cycle. With the macro defined and a silent slave for 256 cycles: done_o with err_o=1.

Source files
------------

// File: rtl/wb_common_pkg.sv
// Shared Wishbone B3 encodings (cycle type, burst type) and the initiator FSM states.
package wb_common_pkg;

  localparam logic [2:0] CLASSIC     = 3'b000;
  localparam logic [2:0] CONST_BURST = 3'b001;
  localparam logic [2:0] INC_BURST   = 3'b010;
  localparam logic [2:0] END_BURST   = 3'b111;

  localparam logic [1:0] LINEAR = 2'b00;
  localparam logic [1:0] WRAP4  = 2'b01;
  localparam logic [1:0] WRAP8  = 2'b10;
  localparam logic [1:0] WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    BUS  = 2'd2
  } state_t;

endpackage

// File: rtl/wb_next_adr.sv
// Next Wishbone beat address: +4 bytes, wrapping the low 2/3/4 word bits for wrap4/8/16.
module wb_next_adr
  import wb_common_pkg::*;
#(
  parameter int aw = 32
) (
  input  logic [aw-1:0] adr,
  input  logic [1:0]    bte,
  output logic [aw-1:0] next_adr
);

  logic [aw-3:0] word;
  logic [aw-3:0] word_inc;
  logic [aw-3:0] next_word;

  always_comb begin
    word     = adr[aw-1:2];
    word_inc = word + (aw-2)'(1);
    case (bte)
      WRAP4:   next_word = {word[aw-3:2], word_inc[1:0]};
      WRAP8:   next_word = {word[aw-3:3], word_inc[2:0]};
      WRAP16:  next_word = {word[aw-3:4], word_inc[3:0]};
      default: next_word = word_inc;
    endcase
    next_adr = {next_word, adr[1:0]};
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst initiator: command port in, classic/incrementing/wrapping cycles out.
// Optional bus watchdog enabled by defining WB_BURST_MASTER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a command, bus released
// FILL  | write buffer empty, cyc held, waiting for a write beat
// BUS   | stb asserted for the current beat (stb low only for one retry gap)
module wb_burst_master
  import wb_common_pkg::*;
#(
  parameter int aw             = 32,
  parameter int dw             = 32,
  parameter int MAX_RETRIES    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic          cmd_we_i,
  input  logic [7:0]    cmd_len_i,
  input  logic [1:0]    cmd_bte_i,
  input  logic [3:0]    cmd_sel_i,
  input  logic [dw-1:0] wdat_i,
  input  logic          wdat_valid_i,
  output logic          wdat_ready_o,
  output logic [dw-1:0] rdat_o,
  output logic          rdat_valid_o,
  output logic          done_o,
  output logic          err_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRIES);

  if (dw != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("wb_burst_master: dw must be 32 and TIMEOUT_CYCLES positive");
  end

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [RW-1:0] rty_q, rty_d;
  logic [aw-1:0] adr_d, next_adr;
  logic [dw-1:0] dat_d, rdat_d;
  logic [3:0]    sel_d;
  logic [2:0]    cti_d;
  logic [1:0]    bte_d;
  logic          we_d, cyc_d, stb_d, rdat_valid_d, done_d, err_d, cmd_ready_d;
  logic          active, resp, timeout, fail, retry, ack;

  wb_next_adr #(.aw(aw)) u_next_adr (
    .adr      (wb_adr_o),
    .bte      (wb_bte_o),
    .next_adr (next_adr)
  );

  assign active = (state_q == BUS) && wb_stb_o;
  assign resp   = active && (wb_ack_i || wb_err_i || wb_rty_i);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wd_q;

  // Counts every BUS cycle without a response, including retry gaps.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                       wd_q <= '0;
    else if (state_q == BUS && !resp)   wd_q <= wd_q + WDW'(1);
    else                                wd_q <= '0;
  end

  assign timeout = (state_q == BUS) && !resp && (wd_q == WD_LAST);
`else
  assign timeout = 1'b0;
`endif

  // Priority err > rty > ack; the retry beyond the budget counts as an error.
  assign fail  = (active && (wb_err_i || (wb_rty_i && rty_q == RTY_MAX))) || timeout;
  assign retry = active && !wb_err_i && wb_rty_i && (rty_q != RTY_MAX);
  assign ack   = active && wb_ack_i && !wb_err_i && !wb_rty_i;

  // Ack-cycle term lets a same-cycle refill keep stb high between write beats.
  assign wdat_ready_o = (state_q == FILL) || (ack && wb_we_o && cnt_q != 8'd0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rty_d        = rty_q;
    adr_d        = wb_adr_o;
    dat_d        = wb_dat_o;
    sel_d        = wb_sel_o;
    we_d         = wb_we_o;
    cyc_d        = wb_cyc_o;
    stb_d        = wb_stb_o;
    cti_d        = wb_cti_o;
    bte_d        = wb_bte_o;
    rdat_d       = rdat_o;
    rdat_valid_d = 1'b0;
    done_d       = 1'b0;
    err_d        = err_o;
    case (state_q)
      IDLE: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        if (cmd_valid_i && cmd_ready_o) begin
          adr_d   = cmd_adr_i;
          sel_d   = cmd_sel_i;
          we_d    = cmd_we_i;
          bte_d   = cmd_bte_i;
          cnt_d   = cmd_len_i;
          rty_d   = '0;
          cti_d   = (cmd_len_i == 8'd0) ? CLASSIC : INC_BURST;
          cyc_d   = 1'b1;
          stb_d   = !cmd_we_i;
          state_d = cmd_we_i ? FILL : BUS;
        end
      end
      FILL: begin
        if (wdat_valid_i) begin
          dat_d   = wdat_i;
          stb_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (fail) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (retry) begin
          rty_d = rty_q + RW'(1);
          stb_d = 1'b0;
        end else if (ack) begin
          rty_d = '0;
          if (!wb_we_o) begin
            rdat_d       = wb_dat_i;
            rdat_valid_d = 1'b1;
          end
          if (cnt_q == 8'd0) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
            adr_d = next_adr;
            cti_d = (cnt_q == 8'd1) ? END_BURST : INC_BURST;
            if (wb_we_o) begin
              if (wdat_valid_i) begin
                dat_d = wdat_i;
              end else begin
                stb_d   = 1'b0;
                state_d = FILL;
              end
            end
          end
        end else if (!wb_stb_o) begin
          stb_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Hold off new commands through the done cycle.
    cmd_ready_d = (state_d == IDLE) && !done_d;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rty_q        <= '0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      wb_we_o      <= 1'b0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_cti_o     <= '0;
      wb_bte_o     <= '0;
      rdat_o       <= '0;
      rdat_valid_o <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      cmd_ready_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rty_q        <= rty_d;
      wb_adr_o     <= adr_d;
      wb_dat_o     <= dat_d;
      wb_sel_o     <= sel_d;
      wb_we_o      <= we_d;
      wb_cyc_o     <= cyc_d;
      wb_stb_o     <= stb_d;
      wb_cti_o     <= cti_d;
      wb_bte_o     <= bte_d;
      rdat_o       <= rdat_d;
      rdat_valid_o <= rdat_valid_d;
      done_o       <= done_d;
      err_o        <= err_d;
      cmd_ready_o  <= cmd_ready_d;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a scripted Wishbone slave.
module tb_wb_burst_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_adr_i = '0;
  logic        cmd_we_i = 1'b0;
  logic [7:0]  cmd_len_i = '0;
  logic [1:0]  cmd_bte_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic [31:0] wdat_i = '0;
  logic        wdat_valid_i = 1'b0;
  logic        wdat_ready_o;
  logic [31:0] rdat_o;
  logic        rdat_valid_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_rty_i = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_burst_master dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_adr_i(cmd_adr_i),
    .cmd_we_i(cmd_we_i), .cmd_len_i(cmd_len_i), .cmd_bte_i(cmd_bte_i), .cmd_sel_i(cmd_sel_i),
    .wdat_i(wdat_i), .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o),
    .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o), .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  int checks = 0;
  int errors = 0;

  // slave script codes per stb-high cycle: 0 wait, 1 ack, 2 rty, 3 err
  int          script[$];
  int          default_resp = 1;
  logic [31:0] ack_adr[$];
  logic [31:0] ack_dat[$];
  logic [2:0]  ack_cti[$];
  logic [1:0]  ack_bte[$];
  logic [3:0]  ack_sel[$];
  logic        ack_we[$];
  logic [31:0] rty_adr[$];
  logic [31:0] rdat_q[$];
  int          hs, ncyc, cyc_gaps;
  logic [63:0] stb_bits;
  logic        done_seen, done_err, done_cyc, done_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hCAFE, a[15:0]};
  endfunction

  function automatic logic [63:0] adr_pack();
    logic [63:0] p = '0;
    foreach (ack_adr[i]) if (i < 8) p = {p[55:0], ack_adr[i][7:0]};
    return p;
  endfunction

  function automatic logic [63:0] cti_pack();
    logic [63:0] p = '0;
    foreach (ack_cti[i]) if (i < 16) p = {p[59:0], 1'b0, ack_cti[i]};
    return p;
  endfunction

  task automatic run(input logic [31:0] adr, input logic [7:0] len, input logic we,
                     input logic [1:0] bte, input logic [3:0] sel, input int gap,
                     input logic [31:0] wbase, input int budget);
    int r;
    int gap_left;
    bit acc;
    bit started;
    ack_adr.delete(); ack_dat.delete(); ack_cti.delete(); ack_bte.delete();
    ack_sel.delete(); ack_we.delete(); rty_adr.delete(); rdat_q.delete();
    hs = 0; ncyc = 0; cyc_gaps = 0; stb_bits = '0;
    done_seen = 0; done_err = 0; done_cyc = 0; done_rdy = 0;
    gap_left = 0; acc = 0; started = 0;
    @(negedge wb_clk_i);
    cmd_adr_i = adr; cmd_len_i = len; cmd_we_i = we; cmd_bte_i = bte; cmd_sel_i = sel;
    cmd_valid_i = 1'b1;
    for (int c = 0; c < budget && !done_seen; c++) begin
      if (c > 0) @(negedge wb_clk_i);
      if (acc) cmd_valid_i = 1'b0;
      if (rdat_valid_o) rdat_q.push_back(rdat_o);
      if (done_o) begin
        done_seen = 1; done_err = err_o; done_cyc = wb_cyc_o; done_rdy = cmd_ready_o;
      end else if (wb_cyc_o) begin
        started = 1; ncyc++; stb_bits = {stb_bits[62:0], wb_stb_o};
      end else if (started) begin
        cyc_gaps++;
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (wb_cyc_o && wb_stb_o) begin
        r = (script.size() > 0) ? script.pop_front() : default_resp;
        case (r)
          1: begin
            wb_ack_i = 1'b1;
            wb_dat_i = word(wb_adr_o);
            ack_adr.push_back(wb_adr_o); ack_dat.push_back(wb_dat_o);
            ack_cti.push_back(wb_cti_o); ack_bte.push_back(wb_bte_o);
            ack_sel.push_back(wb_sel_o); ack_we.push_back(wb_we_o);
          end
          2: begin wb_rty_i = 1'b1; rty_adr.push_back(wb_adr_o); end
          3: wb_err_i = 1'b1;
          default: ;
        endcase
      end
      if (gap_left > 0) begin wdat_valid_i = 1'b0; gap_left--; end
      else wdat_valid_i = 1'b1;
      wdat_i = wbase + hs;
      if (cmd_valid_i && cmd_ready_o) acc = 1;
      #1;
      if (wdat_valid_i && wdat_ready_o) begin hs++; gap_left = gap; end
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    wdat_valid_i = 1'b0; cmd_valid_i = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("cmd_ready_in_done_cycle", done_rdy, 0);
    @(negedge wb_clk_i);
    chk("cmd_ready_after_done", cmd_ready_o, 1);
  endtask

  int done_cnt;

  initial begin
    // reset
    repeat (2) @(negedge wb_clk_i);
    chk("rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_done_rvalid", {done_o, err_o, rdat_valid_o}, 3'b000);
    chk("rst_adr", wb_adr_o, 32'h0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("post_rst_cmd_ready", cmd_ready_o, 1);

    // single read, two wait states
    script = '{0, 0, 1};
    run(32'h100, 8'd0, 1'b0, 2'b00, 4'hF, 0, 32'h0, 50);
    chk("t1_ack_adr", ack_adr[0], 32'h100);
    chk("t1_cti", ack_cti[0], 3'b000);
    chk("t1_rdat_count", rdat_q.size(), 1);
    chk("t1_rdat", rdat_q[0], word(32'h100));
    chk("t1_err", done_err, 0);
    chk("t1_cyc_at_done", done_cyc, 0);
    chk("t1_stb_pattern", {stb_bits, 8'(ncyc)}, {64'h7, 8'd3});

    // zero-wait linear write burst
    run(32'h0, 8'd3, 1'b1, 2'b00, 4'hF, 0, 32'hD000_0000, 50);
    chk("t2_adrs", adr_pack(), 64'h0004080C);
    chk("t2_cti", cti_pack(), 64'h2227);
    chk("t2_hs", hs, 4);
    chk("t2_stb_pattern", {stb_bits, 8'(ncyc)}, {64'h0F, 8'd5});
    chk("t2_dat0", ack_dat[0], 32'hD000_0000);
    chk("t2_dat3", ack_dat[3], 32'hD000_0003);
    chk("t2_err", done_err, 0);

    // wrap4 read from 0x38
    run(32'h38, 8'd3, 1'b0, 2'b01, 4'hF, 0, 32'h0, 50);
    chk("t3_adrs", adr_pack(), 64'h383C3034);
    chk("t3_bte", {ack_bte[0], ack_bte[3]}, 4'b0101);
    chk("t3_rdat_count", rdat_q.size(), 4);
    chk("t3_rdat2", rdat_q[2], word(32'h30));
    chk("t3_rdat3", rdat_q[3], word(32'h34));

    // write with a 5-cycle data gap between beats
    run(32'h80, 8'd1, 1'b1, 2'b00, 4'hF, 5, 32'hB000_0000, 60);
    chk("t4_hs", hs, 2);
    chk("t4_cyc_gaps", cyc_gaps, 0);
    chk("t4_stb_pattern", {stb_bits, 8'(ncyc)}, {64'h41, 8'd8});
    chk("t4_dat1", ack_dat[1], 32'hB000_0001);
    chk("t4_adr1", ack_adr[1], 32'h84);

    // two retries then ack
    script = '{2, 2, 1};
    run(32'h2C4, 8'd0, 1'b0, 2'b00, 4'hF, 0, 32'h0, 50);
    chk("t5_rty_adrs", {rty_adr.size(), rty_adr[0], rty_adr[1]}, {32'd2, 32'h2C4, 32'h2C4});
    chk("t5_ack_adr", ack_adr[0], 32'h2C4);
    chk("t5_stb_pattern", {stb_bits, 8'(ncyc)}, {64'h15, 8'd5});
    chk("t5_err", done_err, 0);

    // five retries exceed the budget
    script = '{2, 2, 2, 2, 2};
    run(32'h2C8, 8'd0, 1'b0, 2'b00, 4'hF, 0, 32'h0, 50);
    chk("t6_err", done_err, 1);
    chk("t6_rty_count", rty_adr.size(), 5);
    chk("t6_stb_pattern", {stb_bits, 8'(ncyc)}, {64'h155, 8'd9});
    chk("t6_no_rdat", rdat_q.size(), 0);

    // err on beat 2 of an 8-beat read
    script = '{1, 1, 3};
    run(32'h400, 8'd7, 1'b0, 2'b00, 4'hF, 0, 32'h0, 50);
    chk("t7_rdat_count", rdat_q.size(), 2);
    chk("t7_rdat1", rdat_q[1], word(32'h404));
    chk("t7_err", done_err, 1);
    chk("t7_cyc_at_done", done_cyc, 0);
    chk("t7_ncyc", ncyc, 3);

    // single write with partial byte select after an error
    run(32'h10, 8'd0, 1'b1, 2'b00, 4'b0011, 0, 32'h1234_0000, 50);
    chk("t8_sel_we_cti", {ack_sel[0], ack_we[0], ack_cti[0]}, {4'b0011, 1'b1, 3'b000});
    chk("t8_dat", ack_dat[0], 32'h1234_0000);
    chk("t8_hs", hs, 1);
    chk("t8_stb_pattern", {stb_bits, 8'(ncyc)}, {64'h1, 8'd2});
    chk("t8_err", done_err, 0);

    // reset in the middle of a transfer
    @(negedge wb_clk_i);
    cmd_adr_i = 32'h600; cmd_len_i = 8'd0; cmd_we_i = 1'b0; cmd_valid_i = 1'b1;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    chk("t9_cyc_stb_before", {wb_cyc_o, wb_stb_o}, 2'b11);
    wb_rst_i = 1'b1;
    #1;
    chk("t9_cyc_stb_async", {wb_cyc_o, wb_stb_o}, 2'b00);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      if (done_o) done_cnt++;
    end
    chk("t9_no_done", done_cnt, 0);
    chk("t9_ready_again", cmd_ready_o, 1);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    // silent slave trips the watchdog
    default_resp = 0;
    run(32'h500, 8'd0, 1'b0, 2'b00, 4'hF, 0, 32'h0, 600);
    chk("t10_err", done_err, 1);
    chk("t10_bus_cycles", ncyc, 256);
    default_resp = 1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
